// File: rtl/reorder_tag_scheduler.sv
// Reorder tag allocator/retirer: hands out tags in order, records per-tag verdicts from
// round-robin arbitrated filter cores, and exposes the head tag's resolution to the buffer.
module reorder_tag_scheduler #(
   parameter int TAG_WIDTH = 6,
   parameter int DEPTH     = 50,
   parameter int N_CORES   = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           alloc_req,
   output logic                           alloc_gnt,
   output logic [TAG_WIDTH-1:0]           alloc_tag,
   input  logic [N_CORES-1:0]             verdict_valid,
   input  logic [N_CORES*TAG_WIDTH-1:0]   verdict_tag,
   input  logic [N_CORES-1:0]             verdict_accept,
   output logic [N_CORES-1:0]             verdict_ready,
   output logic [TAG_WIDTH-1:0]           head_tag,
   output logic [1:0]                     packet_status,
   input  logic                           retire,
   output logic [TAG_WIDTH:0]             occupancy,
   output logic                           full,
   output logic                           empty,
   output logic                           err_verdict,
   output logic                           err_retire
);
   localparam int CW = (N_CORES > 1) ? $clog2(N_CORES) : 1;
   localparam logic [1:0] FREE    = 2'b00;
   localparam logic [1:0] PENDING = 2'b10;
   localparam logic [1:0] ACCEPT  = 2'b11;
   localparam logic [1:0] REJECT  = 2'b01;
   localparam logic [TAG_WIDTH-1:0] LAST_TAG  = TAG_WIDTH'(DEPTH - 1);
   localparam logic [TAG_WIDTH:0]   DEPTH_OCC = (TAG_WIDTH + 1)'(DEPTH);
   localparam logic [CW-1:0]        LAST_CORE = CW'(N_CORES - 1);

   logic [1:0]           slot [DEPTH];
   logic [TAG_WIDTH-1:0] head;
   logic [TAG_WIDTH-1:0] tail;
   logic [TAG_WIDTH:0]   occ;
   logic [CW-1:0]        rr_ptr;

   logic                 grant_vld;
   logic [CW-1:0]        grant_idx;
   logic [TAG_WIDTH-1:0] grant_tag;
   logic                 verdict_hit;
   logic [1:0]           head_state;
   logic                 retire_ok;

   assign full      = (occ == DEPTH_OCC);
   assign empty     = (occ == '0);
   assign occupancy = occ;
   assign head_tag  = head;
   assign alloc_tag = tail;
   assign alloc_gnt = alloc_req & ~full;

   // Rotating priority: first valid requester at or after rr_ptr wins.
   always_comb begin
      int k;
      grant_vld     = 1'b0;
      grant_idx     = '0;
      verdict_ready = '0;
      for (int i = 0; i < N_CORES; i++) begin
         k = (int'(rr_ptr) + i) % N_CORES;
         if (!grant_vld && verdict_valid[k]) begin
            grant_vld        = 1'b1;
            grant_idx        = CW'(k);
            verdict_ready[k] = 1'b1;
         end
      end
   end

   assign grant_tag   = verdict_tag[int'(grant_idx)*TAG_WIDTH +: TAG_WIDTH];
   assign verdict_hit = grant_vld && (int'(grant_tag) < DEPTH) && (slot[grant_tag] == PENDING);

   // Bit 0 of a slot is set exactly for the two resolved states.
   assign head_state    = slot[head];
   assign packet_status = head_state[0] ? head_state : 2'b00;
   assign retire_ok     = retire && !empty && head_state[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) slot[i] <= FREE;
         head        <= '0;
         tail        <= '0;
         occ         <= '0;
         rr_ptr      <= '0;
         err_verdict <= 1'b0;
         err_retire  <= 1'b0;
      end else begin
         // The tail slot is FREE, the head slot is resolved: these writes never collide.
         if (verdict_hit)
            slot[grant_tag] <= verdict_accept[grant_idx] ? ACCEPT : REJECT;
         else if (grant_vld)
            err_verdict <= 1'b1;
         if (grant_vld)
            rr_ptr <= (grant_idx == LAST_CORE) ? '0 : grant_idx + 1'b1;
         if (alloc_gnt) begin
            slot[tail] <= PENDING;
            tail       <= (tail == LAST_TAG) ? '0 : tail + 1'b1;
         end
         if (retire_ok) begin
            slot[head] <= FREE;
            head       <= (head == LAST_TAG) ? '0 : head + 1'b1;
         end else if (retire) begin
            err_retire <= 1'b1;
         end
         case ({alloc_gnt, retire_ok})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end
endmodule

// File: tb/tb_reorder_tag_scheduler.sv
// Bench for reorder_tag_scheduler: vector table, directed corner sequences, randomized run vs queue model.
module tb_reorder_tag_scheduler;
   localparam int TW = 6;
   localparam int D  = 50;
   localparam int NC = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            alloc_req;
   logic            alloc_gnt;
   logic [TW-1:0]   alloc_tag;
   logic [NC-1:0]   verdict_valid;
   logic [NC*TW-1:0] verdict_tag;
   logic [NC-1:0]   verdict_accept;
   logic [NC-1:0]   verdict_ready;
   logic [TW-1:0]   head_tag;
   logic [1:0]      packet_status;
   logic            retire;
   logic [TW:0]     occupancy;
   logic            full, empty, err_verdict, err_retire;

   reorder_tag_scheduler #(.TAG_WIDTH(TW), .DEPTH(D), .N_CORES(NC)) dut (
      .clk(clk), .rst(rst),
      .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag),
      .verdict_valid(verdict_valid), .verdict_tag(verdict_tag),
      .verdict_accept(verdict_accept), .verdict_ready(verdict_ready),
      .head_tag(head_tag), .packet_status(packet_status), .retire(retire),
      .occupancy(occupancy), .full(full), .empty(empty),
      .err_verdict(err_verdict), .err_retire(err_retire)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      alloc_req      = 1'b0;
      retire         = 1'b0;
      verdict_valid  = '0;
      verdict_tag    = '0;
      verdict_accept = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   typedef struct {
      logic a; logic r; logic [3:0] vv; logic [23:0] vt; logic [3:0] va;
      logic g; logic [5:0] t; logic [3:0] rdy; logic [5:0] h; logic [1:0] st; logic [6:0] occ;
   } vec_t;
   vec_t tbl [14];

   // Reference model: slot meaning 0 free, 1 pending, 2 accepted, 3 rejected.
   int ms [D];
   int q [$];
   int m_tail, m_rr;
   bit m_errv, m_errr;

   task automatic model_reset();
      for (int i = 0; i < D; i++) ms[i] = 0;
      q.delete();
      m_tail = 0; m_rr = 0; m_errv = 0; m_errr = 0;
   endtask

   task automatic random_cycle(input int cyc);
      int gk, t, hd, st;
      bit legal;
      alloc_req = ($urandom_range(0, 3) != 0);
      retire    = ((cyc / 200) % 2 == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      for (int k = 0; k < NC; k++) begin
         verdict_valid[k]  = ($urandom_range(0, 2) == 0);
         verdict_accept[k] = $urandom_range(0, 1);
         if (q.size() > 0 && $urandom_range(0, 7) != 0)
            t = q[$urandom_range(0, q.size() - 1)];
         else
            t = $urandom_range(0, 63);
         verdict_tag[k*TW +: TW] = TW'(t);
      end
      #1;
      gk = -1;
      for (int i = 0; i < NC; i++)
         if (gk < 0 && verdict_valid[(m_rr + i) % NC]) gk = (m_rr + i) % NC;
      hd = (q.size() > 0) ? q[0] : m_tail;
      st = (q.size() == 0) ? 0 : (ms[hd] == 2) ? 3 : (ms[hd] == 3) ? 1 : 0;
      chk("rnd_gnt",   int'(alloc_gnt), int'(alloc_req && q.size() < D));
      chk("rnd_tag",   int'(alloc_tag), m_tail);
      chk("rnd_ready", int'(verdict_ready), (gk < 0) ? 0 : (1 << gk));
      chk("rnd_head",  int'(head_tag), hd);
      chk("rnd_status", int'(packet_status), st);
      chk("rnd_occ",   int'(occupancy), q.size());
      chk("rnd_full",  int'(full), int'(q.size() == D));
      chk("rnd_empty", int'(empty), int'(q.size() == 0));
      chk("rnd_errv",  int'(err_verdict), int'(m_errv));
      chk("rnd_errr",  int'(err_retire), int'(m_errr));
      legal = (q.size() > 0) && (ms[hd] >= 2);
      if (gk >= 0) begin
         t = int'(verdict_tag[gk*TW +: TW]);
         if (t < D && ms[t] == 1) ms[t] = verdict_accept[gk] ? 2 : 3;
         else m_errv = 1;
         m_rr = (gk + 1) % NC;
      end
      if (retire) begin
         if (legal) begin ms[hd] = 0; void'(q.pop_front()); end
         else m_errr = 1;
      end
      if (alloc_req && q.size() < D + (legal && retire ? 1 : 0) && !(q.size() + (legal && retire ? 1 : 0) == D)) begin
         ms[m_tail] = 1;
         q.push_back(m_tail);
         m_tail = (m_tail + 1) % D;
      end
      tick();
   endtask

   initial begin
      tbl[0]  = '{1, 0, 4'h0, 24'h0,      4'h0, 1, 0, 4'h0, 0, 2'd0, 0};
      tbl[1]  = '{1, 0, 4'h0, 24'h0,      4'h0, 1, 1, 4'h0, 0, 2'd0, 1};
      tbl[2]  = '{1, 0, 4'h0, 24'h0,      4'h0, 1, 2, 4'h0, 0, 2'd0, 2};
      tbl[3]  = '{0, 0, 4'h0, 24'h0,      4'h0, 0, 3, 4'h0, 0, 2'd0, 3};
      tbl[4]  = '{0, 0, 4'h1, 24'h000001, 4'h1, 0, 3, 4'h1, 0, 2'd0, 3};
      tbl[5]  = '{0, 0, 4'h2, 24'h0,      4'h0, 0, 3, 4'h2, 0, 2'd0, 3};
      tbl[6]  = '{0, 0, 4'h0, 24'h0,      4'h0, 0, 3, 4'h0, 0, 2'd1, 3};
      tbl[7]  = '{0, 1, 4'h0, 24'h0,      4'h0, 0, 3, 4'h0, 0, 2'd1, 3};
      tbl[8]  = '{0, 0, 4'h0, 24'h0,      4'h0, 0, 3, 4'h0, 1, 2'd3, 2};
      tbl[9]  = '{0, 1, 4'h0, 24'h0,      4'h0, 0, 3, 4'h0, 1, 2'd3, 2};
      tbl[10] = '{0, 0, 4'h0, 24'h0,      4'h0, 0, 3, 4'h0, 2, 2'd0, 1};
      tbl[11] = '{1, 0, 4'h4, 24'h002000, 4'h0, 1, 3, 4'h4, 2, 2'd0, 1};
      tbl[12] = '{1, 1, 4'h0, 24'h0,      4'h0, 1, 4, 4'h0, 2, 2'd1, 2};
      tbl[13] = '{0, 0, 4'h0, 24'h0,      4'h0, 0, 5, 4'h0, 3, 2'd0, 2};

      do_reset();
      #1;
      chk("rst_empty", int'(empty), 1);
      chk("rst_full",  int'(full), 0);
      chk("rst_ready", int'(verdict_ready), 0);
      chk("rst_status", int'(packet_status), 0);
      chk("rst_errs",  int'({err_verdict, err_retire}), 0);

      for (int i = 0; i < 14; i++) begin
         alloc_req = tbl[i].a; retire = tbl[i].r; verdict_valid = tbl[i].vv;
         verdict_tag = tbl[i].vt; verdict_accept = tbl[i].va;
         #1;
         chk($sformatf("vec%0d_gnt", i),    int'(alloc_gnt), int'(tbl[i].g));
         chk($sformatf("vec%0d_tag", i),    int'(alloc_tag), int'(tbl[i].t));
         chk($sformatf("vec%0d_ready", i),  int'(verdict_ready), int'(tbl[i].rdy));
         chk($sformatf("vec%0d_head", i),   int'(head_tag), int'(tbl[i].h));
         chk($sformatf("vec%0d_status", i), int'(packet_status), int'(tbl[i].st));
         chk($sformatf("vec%0d_occ", i),    int'(occupancy), int'(tbl[i].occ));
         tick();
      end
      idle_inputs();

      // Round-robin: all four cores at once, then core 2 alone, then rr_ptr must sit at 3.
      do_reset();
      alloc_req = 1'b1;
      repeat (4) tick();
      alloc_req = 1'b0;
      verdict_valid = 4'hF; verdict_accept = 4'hF;
      verdict_tag = {6'd3, 6'd2, 6'd1, 6'd0};
      for (int k = 0; k < NC; k++) begin
         #1;
         chk($sformatf("rr_grant%0d", k), int'(verdict_ready), 1 << k);
         tick();
         verdict_valid[k] = 1'b0;
      end
      verdict_valid = 4'b0100;
      #1;
      chk("rr_core2_alone", int'(verdict_ready), 4);
      tick();
      verdict_valid = 4'hF;
      #1;
      chk("rr_ptr_at_3", int'(verdict_ready), 8);
      chk("rr_head_status", int'(packet_status), 3);
      idle_inputs();
      tick();

      // Full buffer: retire with alloc_req held gives no same-cycle grant, then tag 0 wraps.
      do_reset();
      alloc_req = 1'b1;
      repeat (D) tick();
      #1;
      chk("full_flag", int'(full), 1);
      chk("full_no_gnt", int'(alloc_gnt), 0);
      chk("full_occ", int'(occupancy), D);
      verdict_valid = 4'b0001; verdict_tag = '0; verdict_accept = 4'b0001;
      tick();
      verdict_valid = '0; retire = 1'b1;
      #1;
      chk("full_retire_status", int'(packet_status), 3);
      chk("full_retire_no_gnt", int'(alloc_gnt), 0);
      tick();
      retire = 1'b0;
      #1;
      chk("wrap_gnt", int'(alloc_gnt), 1);
      chk("wrap_tag", int'(alloc_tag), 0);
      chk("wrap_occ_before", int'(occupancy), D - 1);
      tick();
      #1;
      chk("wrap_occ_after", int'(occupancy), D);
      chk("wrap_full", int'(full), 1);
      idle_inputs();

      // Bad verdicts and bad retires.
      do_reset();
      alloc_req = 1'b1;
      tick();
      alloc_req = 1'b0;
      verdict_valid = 4'b0001; verdict_tag = 24'd7; verdict_accept = 4'b0001;
      #1;
      chk("free_tag_ready", int'(verdict_ready), 1);
      tick();
      verdict_valid = '0;
      #1;
      chk("free_tag_errv", int'(err_verdict), 1);
      chk("free_tag_status", int'(packet_status), 0);
      verdict_valid = 4'b0001; verdict_tag = 24'd0; verdict_accept = 4'b0001;
      tick();
      verdict_accept = 4'b0000;
      #1;
      chk("dup_verdict_ready", int'(verdict_ready), 1);
      tick();
      verdict_valid = '0;
      #1;
      chk("dup_verdict_status", int'(packet_status), 3);
      retire = 1'b1;
      tick();
      #1;
      chk("retire_ok_empty", int'(empty), 1);
      chk("retire_ok_noerr", int'(err_retire), 0);
      tick();
      retire = 1'b0;
      #1;
      chk("retire_empty_err", int'(err_retire), 1);
      chk("retire_empty_occ", int'(occupancy), 0);

      // Reset with tags pending and both error flags set.
      do_reset();
      alloc_req = 1'b1;
      repeat (10) tick();
      alloc_req = 1'b0;
      retire = 1'b1;
      verdict_valid = 4'b0001; verdict_tag = 24'd60;
      tick();
      idle_inputs();
      #1;
      chk("pre_rst_errs", int'({err_verdict, err_retire}), 3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("mid_rst_empty", int'(empty), 1);
      chk("mid_rst_head", int'(head_tag), 0);
      chk("mid_rst_tail", int'(alloc_tag), 0);
      chk("mid_rst_status", int'(packet_status), 0);
      chk("mid_rst_errs", int'({err_verdict, err_retire}), 0);
      chk("mid_rst_occ", int'(occupancy), 0);

      // Randomized traffic with periodic resets.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (cyc % 600 == 0) begin
            do_reset();
            model_reset();
         end
         random_cycle(cyc);
      end
      idle_inputs();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
